// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID register, one-entry stall buffer and redirect drain
// Optional build macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect targets trap to TRAP_PC)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter logic [31:0] TRAP_PC  = 32'hBFC00100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic        PcOp,
    input  logic [31:0] ImmExt,
    input  logic [31:0] rs1_val,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PCPlus4_D,
    output logic        valid_D,
    output logic        misalign
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drain_pc;
    logic [31:0] buf_instr;
    logic        ack_eff;
    logic [31:0] base;
    logic [31:0] sum;
    logic [31:0] target;
    logic        trap;

    // an ack only counts while a request is actually outstanding
    assign ack_eff   = imem_ack & imem_req;
    assign imem_addr = pc;

    // redirect target: branch/jal off PC_D, jalr off rs1 with bit 0 cleared
    always_comb begin
        base = PcOp ? rs1_val : PC_D;
        sum  = base + ImmExt;
        if (PcOp) begin
            sum[0] = 1'b0;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        trap   = sum[1];
        target = trap ? TRAP_PC : (sum & ~32'h3);
`else
        trap   = 1'b0;
        target = sum & ~32'h3;
`endif
    end

    // fetch FSM, pc, stall buffer and IF/ID register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            drain_pc  <= RESET_PC;
            buf_instr <= NOP;
            imem_req  <= 1'b0;
            Instr_D   <= NOP;
            PC_D      <= 32'h0;
            PCPlus4_D <= 32'h4;
            valid_D   <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            misalign <= PCSrc & trap;
            imem_req <= 1'b1;
            if (PCSrc) begin
                // flush wins over stall; an in-flight request must finish before retargeting
                Instr_D <= NOP;
                valid_D <= 1'b0;
                if ((state == FETCH && imem_req && !imem_ack) ||
                    (state == DRAIN && !ack_eff)) begin
                    state    <= DRAIN;
                    drain_pc <= target;
                end else begin
                    state <= FETCH;
                    pc    <= target;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (ack_eff && !stall) begin
                            Instr_D   <= imem_rdata;
                            PC_D      <= pc;
                            PCPlus4_D <= pc + 32'd4;
                            valid_D   <= 1'b1;
                            pc        <= pc + 32'd4;
                        end else if (ack_eff) begin
                            buf_instr <= imem_rdata;
                            state     <= HOLD;
                            imem_req  <= 1'b0;
                        end else if (!stall) begin
                            Instr_D <= NOP;
                            valid_D <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        // the drained word belongs to the abandoned path and is dropped
                        if (ack_eff) begin
                            pc    <= drain_pc;
                            state <= FETCH;
                        end
                        if (!stall) begin
                            Instr_D <= NOP;
                            valid_D <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            Instr_D   <= buf_instr;
                            PC_D      <= pc;
                            PCPlus4_D <= pc + 32'd4;
                            valid_D   <= 1'b1;
                            pc        <= pc + 32'd4;
                            state     <= FETCH;
                        end else begin
                            imem_req <= 1'b0;
                        end
                    end
                    default: begin
                        state <= FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_ADDR = 32'hBFC00100;
    localparam logic        MIS_EXP  = 1'b1;
`else
    localparam logic [31:0] MIS_ADDR = 32'hBFC00004;
    localparam logic        MIS_EXP  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic        PcOp = 1'b0;
    logic [31:0] ImmExt = 32'h0;
    logic [31:0] rs1_val = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PCPlus4_D;
    logic        valid_D;
    logic        misalign;

    int lat = 0;
    int wcnt = 0;
    logic force_ack = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic        pcop;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pcd;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .PCSrc     (PCSrc),
        .PcOp      (PcOp),
        .ImmExt    (ImmExt),
        .rs1_val   (rs1_val),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .Instr_D   (Instr_D),
        .PC_D      (PC_D),
        .PCPlus4_D (PCPlus4_D),
        .valid_D   (valid_D),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    // memory model: ack after lat wait cycles, data derived from the address
    assign imem_ack   = (imem_req && (wcnt == lat)) || force_ack;
    assign imem_rdata = imem_addr ^ KEY;

    always @(posedge clk) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic p, input logic op, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ep, input logic em);
        vec_t v;
        v.stall = s; v.pcsrc = p; v.pcop = op; v.imm = imm; v.rs1 = rs1;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pcd = ep; v.e_mis = em;
        vq.push_back(v);
    endtask

    task automatic chk_ifid(input string tag, input logic ev, input logic [31:0] ep);
        chk({tag, ".valid"}, {31'b0, valid_D}, {31'b0, ev});
        chk({tag, ".instr"}, Instr_D, ev ? (ep ^ KEY) : NOP);
        chk({tag, ".pcd"}, PC_D, ep);
        chk({tag, ".pcp4"}, PCPlus4_D, ep + 32'd4);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        // stall, pcsrc, pcop, imm, rs1 | req, addr, valid, pc_d, misalign
        add(0,0,0,32'h0,32'h0,         1,32'hBFC00000,0,32'h00000000,0);
        add(0,0,0,32'h0,32'h0,         1,32'hBFC00004,1,32'hBFC00000,0);
        add(0,0,0,32'h0,32'h0,         1,32'hBFC00008,1,32'hBFC00004,0);
        add(1,0,0,32'h0,32'h0,         0,32'hBFC00008,1,32'hBFC00004,0);
        add(1,0,0,32'h0,32'h0,         0,32'hBFC00008,1,32'hBFC00004,0);
        add(1,0,0,32'h0,32'h0,         0,32'hBFC00008,1,32'hBFC00004,0);
        add(0,0,0,32'h0,32'h0,         1,32'hBFC0000C,1,32'hBFC00008,0);
        add(0,0,0,32'h0,32'h0,         1,32'hBFC00010,1,32'hBFC0000C,0);
        add(0,0,0,32'h0,32'h0,         1,32'hBFC00014,1,32'hBFC00010,0);
        add(0,1,0,32'hFFFFFFF8,32'h0,  1,32'hBFC00008,0,32'hBFC00010,0);
        add(0,0,0,32'h0,32'h0,         1,32'hBFC0000C,1,32'hBFC00008,0);
        add(1,1,1,32'h0,32'hBFC00100,  1,32'hBFC00100,0,32'hBFC00008,0);
        add(0,0,0,32'h0,32'h0,         1,32'hBFC00104,1,32'hBFC00100,0);
        add(1,0,0,32'h0,32'h0,         0,32'hBFC00104,1,32'hBFC00100,0);
        add(0,1,0,32'h20,32'h0,        1,32'hBFC00120,0,32'hBFC00100,0);
        add(0,0,0,32'h0,32'h0,         1,32'hBFC00124,1,32'hBFC00120,0);
        add(0,1,1,32'h0,32'hBFC00006,  1,MIS_ADDR,0,32'hBFC00120,MIS_EXP);
        add(0,0,0,32'h0,32'h0,         1,MIS_ADDR+32'd4,1,MIS_ADDR,0);
        add(0,1,1,32'h0,32'hFFFFFFFC,  1,32'hFFFFFFFC,0,MIS_ADDR,0);
        add(0,0,0,32'h0,32'h0,         1,32'h00000000,1,32'hFFFFFFFC,0);

        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst.req", {31'b0, imem_req}, 32'h0);
        chk("rst.addr", imem_addr, 32'hBFC00000);
        chk("rst.mis", {31'b0, misalign}, 32'h0);
        chk_ifid("rst", 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            stall = vq[i].stall; PCSrc = vq[i].pcsrc; PcOp = vq[i].pcop;
            ImmExt = vq[i].imm; rs1_val = vq[i].rs1;
            step();
            chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, vq[i].e_req});
            chk({tag, ".addr"}, imem_addr, vq[i].e_addr);
            chk({tag, ".mis"}, {31'b0, misalign}, {31'b0, vq[i].e_mis});
            chk_ifid(tag, vq[i].e_valid, vq[i].e_pcd);
        end

        // redirect while a slow fetch is pending: old address held, its data dropped
        stall = 0; PCSrc = 1; PcOp = 1; ImmExt = 32'h0; rs1_val = 32'hBFC00020;
        step();
        chk("dr.addr0", imem_addr, 32'hBFC00020);
        lat = 3;
        PCSrc = 1; PcOp = 1; ImmExt = 32'h3; rs1_val = 32'hBFC00041;
        step();
        PCSrc = 0; ImmExt = 32'h0; rs1_val = 32'h0;
        chk("dr.addr1", imem_addr, 32'hBFC00020);
        chk("dr.req1", {31'b0, imem_req}, 32'h1);
        chk("dr.valid1", {31'b0, valid_D}, 32'h0);
        n = 0;
        while (imem_addr == 32'hBFC00020 && n < 8) begin
            step();
            n++;
            chk($sformatf("dr.valid.c%0d", n), {31'b0, valid_D}, 32'h0);
        end
        chk("dr.cycles", n, 3);
        chk("dr.target", imem_addr, 32'hBFC00044);
        lat = 0;
        step();
        chk_ifid("dr.load", 1'b1, 32'hBFC00044);

        // asynchronous reset in the middle of a slow request, then a stray ack
        lat = 2;
        step();
        #1 rst = 1'b1;
        #1;
        chk("ar.req", {31'b0, imem_req}, 32'h0);
        chk("ar.valid", {31'b0, valid_D}, 32'h0);
        chk("ar.addr", imem_addr, 32'hBFC00000);
        step();
        rst = 1'b0;
        lat = 0;
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        chk("ar.req1", {31'b0, imem_req}, 32'h1);
        chk("ar.addr1", imem_addr, 32'hBFC00000);
        chk_ifid("ar.stray", 1'b0, 32'h0);
        step();
        chk_ifid("ar.first", 1'b1, 32'hBFC00000);
        chk("ar.addr2", imem_addr, 32'hBFC00004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
